// File: rtl/ram_access_ctrl_if.sv
// Request/response channel plus RAM port of the data-RAM sequencer.
// master = core + RAM side, slave = the ram_access_ctrl sequencer.
interface ram_access_ctrl_if #(
  parameter int N = 32,
  parameter int M = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic         req_byte;
  logic [M-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_err;
  logic [M-1:0] ram_address;
  logic [N-1:0] ram_data;
  logic         ram_wren;
  logic [N-1:0] ram_q;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, ram_q,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ram_address, ram_data, ram_wren
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, ram_q,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Word/byte load/store sequencer for a single-port RAM with 1-cycle read latency.
// Optional macro RAM_ACCESS_ADDR_CHECK_EN: out-of-range word index errors instead of wrapping.
module ram_access_ctrl #(
  parameter int N         = 32,
  parameter int M         = 32,
  parameter int MEM_DEPTH = 32
) (
  input logic              clock,
  input logic              reset,
  ram_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MERGE, RESP} state_t;

  state_t       st, st_n;
  logic         we_q, byte_q, err_q;
  logic [1:0]   lane_q;
  logic [7:0]   wbyte_q;
  logic         acc, misal, range_err, req_err;
  logic [M-1:0] widx, widx_map;
  logic         ready_n, wren_n, rvalid_n, rerr_n;
  logic [M-1:0] addr_n;
  logic [N-1:0] data_n, rdata_n, merged;
  logic [7:0]   qbyte;

  assign acc   = bus.req_valid && bus.req_ready;
  assign widx  = {2'b00, bus.req_addr[M-1:2]};
  assign misal = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);

`ifdef RAM_ACCESS_ADDR_CHECK_EN
  assign range_err = (widx >= M'(MEM_DEPTH));
  assign widx_map  = widx;
`else
  assign range_err = 1'b0;
  assign widx_map  = widx % M'(MEM_DEPTH);
`endif

  assign req_err = misal || range_err;
  assign qbyte   = bus.ram_q[{lane_q, 3'b000} +: 8];

  always_comb begin
    merged = bus.ram_q;
    merged[{lane_q, 3'b000} +: 8] = wbyte_q;
  end

  always_ff @(posedge clock) begin
    if (reset) st <= IDLE;
    else       st <= st_n;
  end

  // Next-state plus next values of the registered outputs
  always_comb begin
    st_n    = st;
    wren_n  = 1'b0;
    addr_n  = bus.ram_address;
    data_n  = bus.ram_data;
    rdata_n = bus.resp_rdata;
    case (st)
      IDLE: if (acc) begin
        rdata_n = '0;
        if (req_err) st_n = RESP;
        else begin
          st_n   = ISSUE;
          addr_n = widx_map;
          data_n = bus.req_wdata;
          wren_n = bus.req_we && !bus.req_byte;
        end
      end
      ISSUE: st_n = (we_q && !byte_q) ? RESP : WAIT;
      WAIT: begin
        if (we_q) begin
          st_n   = MERGE;
          wren_n = 1'b1;
          data_n = merged;
        end else begin
          st_n    = RESP;
          rdata_n = byte_q ? {{(N-8){1'b0}}, qbyte} : bus.ram_q;
        end
      end
      MERGE:   st_n = RESP;
      RESP:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
    ready_n  = (st_n == IDLE);
    rvalid_n = (st == RESP);
    rerr_n   = (st == RESP) && err_q;
  end

  // Response pulses in the cycle after RESP, together with req_ready
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.ram_address <= '0;
      bus.ram_data    <= '0;
      bus.ram_wren    <= 1'b0;
    end else begin
      bus.req_ready   <= ready_n;
      bus.resp_valid  <= rvalid_n;
      bus.resp_err    <= rerr_n;
      bus.resp_rdata  <= rdata_n;
      bus.ram_address <= addr_n;
      bus.ram_data    <= data_n;
      bus.ram_wren    <= wren_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      lane_q  <= 2'b00;
      wbyte_q <= 8'h00;
    end else if (acc) begin
      we_q    <= bus.req_we;
      byte_q  <= bus.req_byte;
      err_q   <= req_err;
      lane_q  <= bus.req_addr[1:0];
      wbyte_q <= bus.req_wdata[7:0];
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural single-port RAM model.
module tb_ram_access_ctrl;
  localparam int N = 32, M = 32, MEM_DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_access_ctrl_if #(.N(N), .M(M)) bus();
  ram_access_ctrl #(.N(N), .M(M), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clock(clk), .reset(rst), .bus(bus.slave)
  );

  logic [N-1:0] mem [MEM_DEPTH] = '{default: '0};
  int           wren_cnt = 0;
  logic [M-1:0] wr_addr = '0;
  logic [N-1:0] wr_data = '0;

  always @(posedge clk) begin
    if (bus.ram_wren) begin
      mem[bus.ram_address[4:0]] <= bus.ram_data;
      wren_cnt <= wren_cnt + 1;
      wr_addr  <= bus.ram_address;
      wr_data  <= bus.ram_data;
    end
    bus.ram_q <= mem[bus.ram_address[4:0]];
  end

  typedef struct {
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wr;
    logic [31:0] wdat;
    logic [31:0] waddr;
  } vec_t;

  vec_t v[15];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_req(input vec_t r, input string nm);
    int n, lat, w0;
    @(negedge clk);
    bus.req_we = r.we; bus.req_byte = r.bt;
    bus.req_addr = r.addr; bus.req_wdata = r.wdata; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, " accept"}, 32'(n < 20), 32'd1);
    w0 = wren_cnt;
    @(negedge clk);
    // scramble request inputs after accept; they must be ignored
    bus.req_valid = 1'b0; bus.req_addr = '1; bus.req_wdata = 32'hDEADBEEF;
    bus.req_we = ~r.we; bus.req_byte = ~r.bt;
    lat = 0;
    while (!bus.resp_valid && lat < 12) begin @(negedge clk); lat++; end
    chk({nm, " lat"}, 32'(lat), 32'(r.lat));
    chk({nm, " err"}, 32'(bus.resp_err), 32'(r.err));
    chk({nm, " rdata"}, bus.resp_rdata, r.rdata);
    chk({nm, " wren"}, 32'(wren_cnt - w0), 32'(r.wr));
    if (!r.err) chk({nm, " ram_address"}, bus.ram_address, r.waddr);
    if (r.wr > 0) begin
      chk({nm, " wr_data"}, wr_data, r.wdat);
      chk({nm, " wr_addr"}, wr_addr, r.waddr);
    end
  endtask

  initial begin
    int k, rdy, w0, seen;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;

    //        we    bt    addr      wdata          err   rdata          lat wr wdat           waddr
    v[0]  = '{1'b1, 1'b0, 32'd0,   32'd369,       1'b0, 32'd0,         2, 1, 32'd369,       32'd0};
    v[1]  = '{1'b0, 1'b0, 32'd0,   32'd0,         1'b0, 32'd369,       3, 0, 32'd0,         32'd0};
    v[2]  = '{1'b1, 1'b0, 32'd4,   32'd123,       1'b0, 32'd0,         2, 1, 32'd123,       32'd1};
    v[3]  = '{1'b1, 1'b1, 32'd5,   32'hFFFFFFAB,  1'b0, 32'd0,         4, 1, 32'h0000AB7B,  32'd1};
    v[4]  = '{1'b0, 1'b0, 32'd4,   32'd0,         1'b0, 32'h0000AB7B,  3, 0, 32'd0,         32'd1};
    v[5]  = '{1'b0, 1'b1, 32'd5,   32'd0,         1'b0, 32'h000000AB,  3, 0, 32'd0,         32'd1};
    v[6]  = '{1'b0, 1'b1, 32'd4,   32'd0,         1'b0, 32'h0000007B,  3, 0, 32'd0,         32'd1};
    v[7]  = '{1'b0, 1'b0, 32'd6,   32'd0,         1'b1, 32'd0,         1, 0, 32'd0,         32'd0};
    v[8]  = '{1'b1, 1'b0, 32'd2,   32'd55,        1'b1, 32'd0,         1, 0, 32'd0,         32'd0};
`ifdef RAM_ACCESS_ADDR_CHECK_EN
    v[9]  = '{1'b0, 1'b0, 32'd128, 32'd0,         1'b1, 32'd0,         1, 0, 32'd0,         32'd0};
`else
    v[9]  = '{1'b0, 1'b0, 32'd128, 32'd0,         1'b0, 32'd369,       3, 0, 32'd0,         32'd0};
`endif
    v[10] = '{1'b1, 1'b1, 32'd7,   32'h1234565C,  1'b0, 32'd0,         4, 1, 32'h5C00AB7B,  32'd1};
    v[11] = '{1'b0, 1'b0, 32'd4,   32'd0,         1'b0, 32'h5C00AB7B,  3, 0, 32'd0,         32'd1};
    v[12] = '{1'b0, 1'b1, 32'd3,   32'd0,         1'b0, 32'd0,         3, 0, 32'd0,         32'd0};
`ifdef RAM_ACCESS_ADDR_CHECK_EN
    v[13] = '{1'b1, 1'b1, 32'd130, 32'h000000EE,  1'b1, 32'd0,         1, 0, 32'd0,         32'd0};
    v[14] = '{1'b0, 1'b0, 32'd0,   32'd0,         1'b0, 32'd369,       3, 0, 32'd0,         32'd0};
`else
    v[13] = '{1'b1, 1'b1, 32'd130, 32'h000000EE,  1'b0, 32'd0,         4, 1, 32'h00EE0171,  32'd0};
    v[14] = '{1'b0, 1'b0, 32'd0,   32'd0,         1'b0, 32'h00EE0171,  3, 0, 32'd0,         32'd0};
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst ram_wren", 32'(bus.ram_wren), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst ram_address", bus.ram_address, 32'd0);
    chk("rst ram_data", bus.ram_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_req(v[i], $sformatf("vec%0d", i));

    // back-to-back: store 999 to addr 8 with a load of addr 8 queued behind it
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_byte = 1'b0; bus.req_addr = 32'd8;
    bus.req_wdata = 32'd999; bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    chk("b2b store accept", 32'(k < 20), 32'd1);
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_wdata = 32'd0;
    k = 0; rdy = 0;
    while (!bus.resp_valid && k < 12) begin
      if (bus.req_ready) rdy++;
      @(negedge clk); k++;
    end
    chk("b2b store lat", 32'(k), 32'd2);
    chk("b2b ready low during store", 32'(rdy), 32'd0);
    chk("b2b ready with resp", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0; rdy = 0;
    while (!bus.resp_valid && k < 12) begin
      if (bus.req_ready) rdy++;
      @(negedge clk); k++;
    end
    chk("b2b load lat", 32'(k), 32'd3);
    chk("b2b ready low during load", 32'(rdy), 32'd0);
    chk("b2b load rdata", bus.resp_rdata, 32'd999);
    chk("b2b load err", 32'(bus.resp_err), 32'd0);

    // reset during WAIT of a byte store to addr 4
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_byte = 1'b1; bus.req_addr = 32'd4;
    bus.req_wdata = 32'h00000011; bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    w0 = wren_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst ram_wren", 32'(bus.ram_wren), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid) seen++;
      @(negedge clk);
    end
    chk("midrst no resp", 32'(seen), 32'd0);
    chk("midrst no write", 32'(wren_cnt - w0), 32'd0);
    chk("midrst word1 model", mem[1], 32'h5C00AB7B);
    run_req('{1'b0, 1'b0, 32'd4, 32'd0, 1'b0, 32'h5C00AB7B, 3, 0, 32'd0, 32'd1}, "post-rst load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
